// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
// Bundles every signal between the fetch queue and its three neighbours:
// the program counter, instruction memory and the decode stage.
//   PC side     : pcIn, pcAdvance, branch
//   memory side : memReq, memAddr, memGnt, memValid, memData
//   decode side : instValid, instData, instAddr, instReady, qCount
// Modport slave is taken by inst_fetch_queue.
// Modport master is taken by whatever drives it (PC, memory, decode or a bench).

`ifndef instAddrLen
`define instAddrLen 8
`endif

interface inst_fetch_queue_if #(
    parameter int ADDR_W = `instAddrLen,
    parameter int INST_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pcIn;
    logic              pcAdvance;
    logic              branch;
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic              memGnt;
    logic              memValid;
    logic [INST_W-1:0] memData;
    logic              instValid;
    logic [INST_W-1:0] instData;
    logic [ADDR_W-1:0] instAddr;
    logic              instReady;
    logic [CNT_W-1:0]  qCount;

    modport slave (
        input  pcIn, branch, memGnt, memValid, memData, instReady,
        output pcAdvance, memReq, memAddr, instValid, instData, instAddr, qCount
    );

    modport master (
        output pcIn, branch, memGnt, memValid, memData, instReady,
        input  pcAdvance, memReq, memAddr, instValid, instData, instAddr, qCount
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Fetch stage behind the program counter. It issues in-order reads to
// instruction memory and tags each one with its address. Returned words are
// buffered in a DEPTH-entry queue for decode. On a taken branch, the queue is
// flushed and the responses still in flight are dropped.
// Ports:
//   clk   - clock; everything is on posedge
//   reset - synchronous, active-high
//   bus   - inst_fetch_queue_if.slave (PC, memory and decode handshakes)
// Optional feature: define FETCH_TRACE_EN to print flush/resume trace
// messages in simulation. The logic is identical either way.

`ifndef instAddrLen
`define instAddrLen 8
`endif

module inst_fetch_queue #(
    parameter int ADDR_W = `instAddrLen,
    parameter int INST_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

    stateT             state;
    logic [INST_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [ADDR_W-1:0] tagMem  [DEPTH];
    logic [PTR_W-1:0]  head, tail, tagHead, tagTail;
    logic [CNT_W-1:0]  count, inflight, discard;
    logic [INST_W-1:0] headData;
    logic [ADDR_W-1:0] headAddr;

    logic              reqInt, fire, pop, push;
    logic [CNT_W:0]    credit;
    logic [CNT_W-1:0]  countAfterPop, countNext, inflightNext;
    logic [PTR_W-1:0]  headNext;
    logic [ADDR_W-1:0] tagOut;

    // Queue slots plus outstanding requests never exceed DEPTH.
    // Because of that credit limit, a returning word always has a free slot.
    always_comb begin
        credit        = {1'b0, count} + {1'b0, inflight};
        reqInt        = (state == RUN) && !bus.branch && (credit < (CNT_W+1)'(DEPTH));
        fire          = reqInt && bus.memGnt;
        pop           = (count != '0) && bus.instReady;
        push          = bus.memValid && (state == RUN) && !bus.branch;
        tagOut        = tagMem[tagHead];
        headNext      = head + PTR_W'(pop);
        countAfterPop = count - CNT_W'(pop);
        countNext     = countAfterPop + CNT_W'(push);
        inflightNext  = inflight + CNT_W'(fire) - CNT_W'(bus.memValid);
    end

    assign bus.memReq    = reqInt;
    assign bus.memAddr   = bus.pcIn;
    assign bus.pcAdvance = fire;
    assign bus.instValid = (count != '0);
    assign bus.instData  = headData;
    assign bus.instAddr  = headAddr;
    assign bus.qCount    = count;

    // The head registers are loaded only when the queue will be non-empty next
    // cycle, so they keep the last shown instruction once the queue empties.
    // When the queue is empty after the pop, the incoming word becomes the head.
    // That gives one cycle of latency and no combinational bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            tagHead  <= '0;
            tagTail  <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            headData <= '0;
            headAddr <= '0;
        end else begin
            if (fire) begin
                tagMem[tagTail] <= bus.pcIn;
                tagTail         <= tagTail + 1'b1;
            end
            if (bus.memValid) begin
                tagHead <= tagHead + 1'b1;
            end
            inflight <= inflightNext;

            if (bus.branch) begin
                // No request fired this cycle.
                // Everything still in flight after this cycle is stale.
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                discard <= inflightNext;
                state   <= (inflightNext != '0) ? DRAIN : RUN;
`ifdef FETCH_TRACE_EN
                $write("\nfetch flush, discarding %d in flight", inflightNext);
`endif
            end else begin
                if (push) begin
                    dataMem[tail] <= bus.memData;
                    addrMem[tail] <= tagOut;
                    tail          <= tail + 1'b1;
                end
                head  <= headNext;
                count <= countNext;
                if (countNext != '0) begin
                    if (countAfterPop != '0) begin
                        headData <= dataMem[headNext];
                        headAddr <= addrMem[headNext];
                    end else begin
                        headData <= bus.memData;
                        headAddr <= tagOut;
                    end
                end

                case (state)
                    IDLE:    state <= RUN;
                    RUN:     state <= RUN;
                    DRAIN: begin
                        if (bus.memValid) begin
                            discard <= discard - 1'b1;
                            if (discard == CNT_W'(1)) begin
                                state <= RUN;
`ifdef FETCH_TRACE_EN
                                $write("\nfetch resumed at %h", bus.pcIn);
`endif
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current instruction address from the PC, issues reads to instruction memory, and buffers returned words in an in-order queue for the decode stage.
- Tells the PC when to advance, and flushes stale fetches when a branch is taken.

Parameters:
ADDR_W, 8, instruction address width; the top level sets it equal to `instAddrLen.
INST_W, 16, instruction word width.
DEPTH, 4, queue entries; power of 2, minimum 2; also the maximum number of requests in flight.

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
pcIn  in  ADDR_W  current address from the program counter
pcAdvance  out  1  high in each cycle a memory request fires; gates the PC increment
branch  in  1  branch taken this cycle; the PC loads its target at this edge
memReq  out  1  memory read request
memAddr  out  ADDR_W  request address; equals pcIn whenever memReq=1
memGnt  in  1  memory accepts the request this cycle (fire = memReq & memGnt)
memValid  in  1  read data returned; responses arrive in request order
memData  in  INST_W  returned instruction word
instValid  out  1  queue head valid
instData  out  INST_W  queue head instruction
instAddr  out  ADDR_W  address of the queue head instruction
instReady  in  1  decode accepts the head (pop = instValid & instReady)
qCount  out  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- FSM states:
  - IDLE: first cycle after reset; no requests issued; goes to RUN.
  - RUN: normal fetching.
  - DRAIN: discards responses from requests that were in flight at a branch.
- Reset, synchronous, highest priority:
  - Outputs: memReq=0, pcAdvance=0, instValid=0, qCount=0, instData=0, instAddr=0.
  - Internal: queue pointers, inflight count and discard count cleared; state=IDLE.
  - Mid-operation reset drops all entries. The memory port shares this reset, so no responses arrive after it.
- Request issue (combinational): memReq = (state==RUN) & !branch & (qCount + inflight < DEPTH).
  - memAddr = pcIn.
  - pcAdvance = memReq & memGnt.
- memReq may drop without a grant only on branch. Otherwise it stays high until granted.
- Each fire pushes pcIn into an address-tag FIFO of depth DEPTH and increments inflight.
- Each memValid pops the tag FIFO and decrements inflight.
  - In RUN: {memData, tag} is written to the queue tail.
  - In DRAIN: the word is discarded and the discard count decrements.
- Fire and memValid in the same cycle: inflight unchanged.
- Latency: a word returned in cycle N appears on instValid/instData in cycle N+1. No bypass from memory to output.
- Pop and push in the same cycle at qCount==DEPTH is legal. Overflow is impossible because issue is credit-limited.
- Branch in cycle N:
  - No request fires in N.
  - A pop in N by decode still completes.
  - At the edge ending N: all queue entries are flushed, qCount=0, and any memValid in N is discarded.
  - discard count = inflight after N's accounting.
  - If discard count > 0: state = DRAIN. Otherwise stay in RUN.
  - Requests resume in N+1 at the new pcIn (the branch target).
- DRAIN -> RUN when the discard count reaches 0 on a memValid.
- Branch during DRAIN adds nothing, since inflight is already counted. The queue is already empty; state stays DRAIN.
- Queue empty: instValid=0; instData/instAddr hold their last values.
- Address arithmetic wraps modulo 2^ADDR_W, matching the PC.

Optional Feature:
- Macro FETCH_TRACE_EN.
- Defined:
  - On each branch: $write of "\nfetch flush, discarding %d in flight".
  - On each DRAIN->RUN transition: $write of "\nfetch resumed at %h" with pcIn.
- Undefined: no simulation output; logic is identical.

Test Plan:
- Reset, memGnt=1, memValid two cycles after each fire, instReady=1, pcIn sequence 00,01,02... -> instAddr 00,01,02 in order with the matching data; pcAdvance high every cycle after IDLE.
- instReady=0 with 1-cycle memory -> exactly 4 fires; memReq low with qCount=4; one pop re-enables exactly one fire.
- branch with 3 requests in flight (addr 05,06,07), target 20 -> state DRAIN; the 3 responses dropped; first queued instAddr=20; qCount=0 after the flush edge.
- branch in the same cycle as memValid and an instReady pop -> popped word delivered; returning word discarded; queue empty next cycle.
- memGnt=0 for 3 cycles with memReq=1 -> memAddr stable, pcAdvance=0 throughout; fires on the 4th cycle.
- reset asserted with 2 queued and 2 in flight -> next cycle all outputs at their reset values; state IDLE, then RUN.
